// File: rtl/clk_gen_multi_if.sv
// Handshake/data bundle for clk_gen_multi: divisor configuration in,
// per-channel strobes, square waves and lock status out.
interface clk_gen_multi_if #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned CNT_W  = 8
);
    logic [NUM_CH*CNT_W-1:0] div_in;
    logic                    cfg_load;
    logic [NUM_CH-1:0]       ch_en;
    logic [NUM_CH-1:0]       ce_out;
    logic [NUM_CH-1:0]       clk_out;
    logic                    locked;

    modport master (
        output div_in, cfg_load, ch_en,
        input  ce_out, clk_out, locked
    );

    modport slave (
        input  div_in, cfg_load, ch_en,
        output ce_out, clk_out, locked
    );
endinterface

// File: rtl/clk_gen_multi.sv
// Multi-channel clock-enable generator: a lock FSM models PLL settle time,
// then NUM_CH phase-aligned divider channels emit strobes and square waves.
module clk_gen_multi #(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned LOCK_CYCLES = 16
) (
    input  logic           clock_in,
    input  logic           reset,
    clk_gen_multi_if.slave bus
);
    localparam int unsigned      SET_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(LOCK_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_SETTLE,
        ST_LOCKED
    } state_e;

    state_e            state_q, state_d;
    logic [SET_W-1:0]  settle_q, settle_d;
    logic [CNT_W-1:0]  shadow_q [NUM_CH];
    logic [CNT_W-1:0]  shadow_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_q    [NUM_CH];
    logic [CNT_W-1:0]  cnt_d    [NUM_CH];
    logic [NUM_CH-1:0] run_q, run_d;

    logic [CNT_W-1:0]  eff      [NUM_CH];
    logic [CNT_W-1:0]  last     [NUM_CH];
    logic [CNT_W-1:0]  high_lim [NUM_CH];
    logic [NUM_CH-1:0] live;

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_q  <= ST_LOAD;
            settle_q <= '0;
            shadow_q <= '{default: '0};
            cnt_q    <= '{default: '0};
            run_q    <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
        end
    end

    // A reload during SETTLE detours through LOAD so every reload sees the
    // same LOAD + LOCK_CYCLES settle sequence before lock.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        shadow_d = shadow_q;
        unique case (state_q)
            ST_LOAD: begin
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    shadow_d[i] = bus.div_in[i*CNT_W +: CNT_W];
                end
                settle_d = '0;
                state_d  = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (bus.cfg_load) begin
                    settle_d = '0;
                    state_d  = ST_LOAD;
                end else if (settle_q == SET_LAST) begin
                    settle_d = '0;
                    state_d  = ST_LOCKED;
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            ST_LOCKED: begin
                if (bus.cfg_load) begin
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    // run_q delays ch_en by one edge so a re-enabled channel shows cnt=0
    // in its first live cycle and outputs decode from flops only.
    always_comb begin
        run_d       = bus.ch_en;
        eff         = '{default: '0};
        last        = '{default: '0};
        high_lim    = '{default: '0};
        cnt_d       = '{default: '0};
        live        = '0;
        bus.ce_out  = '0;
        bus.clk_out = '0;
        bus.locked  = (state_q == ST_LOCKED);
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            eff[i]      = (shadow_q[i] == '0) ? CNT_W'(1) : shadow_q[i];
            last[i]     = eff[i] - CNT_W'(1);
            high_lim[i] = eff[i] - (eff[i] >> 1);
            live[i]     = (state_q == ST_LOCKED) && run_q[i];
            if (live[i] && bus.ch_en[i] && (cnt_q[i] != last[i])) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
            bus.ce_out[i]  = live[i] && (cnt_q[i] == last[i]);
            bus.clk_out[i] = live[i] && (cnt_q[i] < high_lim[i]);
        end
    end
endmodule

// File: tb/tb_clk_gen_multi.sv
// Self-checking bench for clk_gen_multi: directed scenarios plus random
// traffic, compared against a cycle-count/modulo reference model.
module tb_clk_gen_multi;
    localparam int NUM_CH      = 2;
    localparam int CNT_W       = 8;
    localparam int LOCK_CYCLES = 16;

    logic clock_in = 1'b0;
    logic reset    = 1'b1;

    clk_gen_multi_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

    clk_gen_multi #(
        .NUM_CH(NUM_CH),
        .CNT_W(CNT_W),
        .LOCK_CYCLES(LOCK_CYCLES)
    ) dut (
        .clock_in(clock_in),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock_in = ~clock_in;

    int checks   = 0;
    int failures = 0;

    // Reference model: edges remaining until lock, and per channel the
    // number of live cycles since the channel (re)started.
    bit m_locked;
    int m_left;
    int m_age [NUM_CH];
    bit m_run [NUM_CH];
    int m_div [NUM_CH];

    function automatic void model_edge();
        bit was_locked;
        if (reset) begin
            m_locked = 1'b0;
            m_left   = LOCK_CYCLES + 1;
            for (int i = 0; i < NUM_CH; i++) begin
                m_age[i] = 0;
                m_run[i] = 1'b0;
                m_div[i] = 0;
            end
        end else begin
            was_locked = m_locked;
            for (int i = 0; i < NUM_CH; i++) begin
                if (was_locked && m_run[i] && bus.ch_en[i]) m_age[i] = m_age[i] + 1;
                else m_age[i] = 0;
                m_run[i] = bus.ch_en[i];
            end
            if (was_locked) begin
                if (bus.cfg_load) begin
                    m_locked = 1'b0;
                    m_left   = LOCK_CYCLES + 1;
                end
            end else if (m_left == LOCK_CYCLES + 1) begin
                for (int i = 0; i < NUM_CH; i++) m_div[i] = int'(bus.div_in[i*CNT_W +: CNT_W]);
                m_left = m_left - 1;
            end else if (bus.cfg_load) begin
                m_left = LOCK_CYCLES + 1;
            end else begin
                m_left = m_left - 1;
                if (m_left == 0) m_locked = 1'b1;
            end
        end
    endfunction

    function automatic logic [NUM_CH-1:0] m_ce();
        logic [NUM_CH-1:0] r;
        int d;
        for (int i = 0; i < NUM_CH; i++) begin
            d    = (m_div[i] == 0) ? 1 : m_div[i];
            r[i] = m_locked && m_run[i] && ((m_age[i] % d) == d - 1);
        end
        return r;
    endfunction

    function automatic logic [NUM_CH-1:0] m_clk();
        logic [NUM_CH-1:0] r;
        int d;
        for (int i = 0; i < NUM_CH; i++) begin
            d    = (m_div[i] == 0) ? 1 : m_div[i];
            r[i] = m_locked && m_run[i] && ((m_age[i] % d) < (d + 1) / 2);
        end
        return r;
    endfunction

    task automatic step();
        model_edge();
        @(posedge clock_in);
        #1;
    endtask

    task automatic set_div(input int d1, input int d0);
        bus.div_in = {CNT_W'(d1), CNT_W'(d0)};
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.cfg_load = 1'b0;
        bus.ch_en = 2'b11;
        set_div(3, 4);
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if ({bus.locked, bus.ce_out, bus.clk_out} !== 5'b0) begin
                failures++;
                $display("FAIL reset_outputs cycle=%0d actual=%b expected=00000", c,
                         {bus.locked, bus.ce_out, bus.clk_out});
            end
        end
    endtask

    task automatic test_lock_basic();
        int k;
        reset = 1'b1;
        set_div(3, 4);
        bus.ch_en = 2'b11;
        step();
        reset = 1'b0;
        for (int e = 1; e <= 41; e++) begin
            step();
            checks++;
            if ({bus.locked, bus.ce_out, bus.clk_out} !== {m_locked, m_ce(), m_clk()}) begin
                failures++;
                $display("FAIL lock_model edge=%0d actual=%b expected=%b", e,
                         {bus.locked, bus.ce_out, bus.clk_out}, {m_locked, m_ce(), m_clk()});
            end
            checks++;
            if (bus.locked !== (e >= 17)) begin
                failures++;
                $display("FAIL lock_time edge=%0d actual=%b expected=%b", e, bus.locked, e >= 17);
            end
            if (e >= 17) begin
                k = e - 17;
                checks++;
                if ({bus.ce_out, bus.clk_out} !== {k % 3 == 2, k % 4 == 3, k % 3 < 2, k % 4 < 2}) begin
                    failures++;
                    $display("FAIL lock_pattern k=%0d actual=%b expected=%b", k,
                             {bus.ce_out, bus.clk_out}, {k % 3 == 2, k % 4 == 3, k % 3 < 2, k % 4 < 2});
                end
            end
        end
    endtask

    task automatic test_ch_en();
        for (int c = 0; c < 12; c++) begin
            bus.ch_en = (c >= 2 && c < 7) ? 2'b10 : 2'b11;
            step();
            checks++;
            if ({bus.locked, bus.ce_out, bus.clk_out} !== {m_locked, m_ce(), m_clk()}) begin
                failures++;
                $display("FAIL chen_model cycle=%0d actual=%b expected=%b", c,
                         {bus.locked, bus.ce_out, bus.clk_out}, {m_locked, m_ce(), m_clk()});
            end
            if (c >= 2 && c < 7) begin
                checks++;
                if ({bus.ce_out[0], bus.clk_out[0]} !== 2'b00) begin
                    failures++;
                    $display("FAIL chen_off cycle=%0d actual=%b expected=00", c,
                             {bus.ce_out[0], bus.clk_out[0]});
                end
            end
            if (c == 7) begin
                checks++;
                if (bus.clk_out[0] !== 1'b1) begin
                    failures++;
                    $display("FAIL chen_restart actual=%b expected=1", bus.clk_out[0]);
                end
            end
        end
    endtask

    task automatic test_redivide();
        int k;
        set_div(3, 6);
        bus.cfg_load = 1'b1;
        step();
        bus.cfg_load = 1'b0;
        checks++;
        if ({bus.locked, bus.ce_out, bus.clk_out} !== 5'b0) begin
            failures++;
            $display("FAIL redivide_drop actual=%b expected=00000", {bus.locked, bus.ce_out, bus.clk_out});
        end
        for (int e = 1; e <= 17 + 12; e++) begin
            step();
            checks++;
            if ({bus.locked, bus.ce_out, bus.clk_out} !== {m_locked, m_ce(), m_clk()}) begin
                failures++;
                $display("FAIL redivide_model edge=%0d actual=%b expected=%b", e,
                         {bus.locked, bus.ce_out, bus.clk_out}, {m_locked, m_ce(), m_clk()});
            end
            checks++;
            if (bus.locked !== (e >= 17)) begin
                failures++;
                $display("FAIL redivide_lock edge=%0d actual=%b expected=%b", e, bus.locked, e >= 17);
            end
            if (e >= 17) begin
                k = e - 17;
                checks++;
                if (bus.clk_out[0] !== (k % 6 < 3)) begin
                    failures++;
                    $display("FAIL redivide_ch0 k=%0d actual=%b expected=%b", k, bus.clk_out[0], k % 6 < 3);
                end
            end
        end
    endtask

    task automatic test_div01();
        set_div(1, 0);
        bus.cfg_load = 1'b1;
        step();
        bus.cfg_load = 1'b0;
        for (int e = 1; e <= 17 + 8; e++) begin
            step();
            checks++;
            if ({bus.locked, bus.ce_out, bus.clk_out} !== {m_locked, m_ce(), m_clk()}) begin
                failures++;
                $display("FAIL div01_model edge=%0d actual=%b expected=%b", e,
                         {bus.locked, bus.ce_out, bus.clk_out}, {m_locked, m_ce(), m_clk()});
            end
            if (e >= 17) begin
                checks++;
                if ({bus.ce_out, bus.clk_out} !== 4'b1111) begin
                    failures++;
                    $display("FAIL div01_const edge=%0d actual=%b expected=1111", e, {bus.ce_out, bus.clk_out});
                end
            end
        end
    endtask

    task automatic test_settle_restart();
        bus.cfg_load = 1'b1;
        step();
        bus.cfg_load = 1'b0;
        for (int e = 1; e <= 11; e++) step();
        bus.cfg_load = 1'b1;
        step();
        bus.cfg_load = 1'b0;
        for (int e = 1; e <= 18; e++) begin
            step();
            checks++;
            if (bus.locked !== (e >= 17)) begin
                failures++;
                $display("FAIL restart_lock edge=%0d actual=%b expected=%b", e, bus.locked, e >= 17);
            end
            checks++;
            if ({bus.locked, bus.ce_out, bus.clk_out} !== {m_locked, m_ce(), m_clk()}) begin
                failures++;
                $display("FAIL restart_model edge=%0d actual=%b expected=%b", e,
                         {bus.locked, bus.ce_out, bus.clk_out}, {m_locked, m_ce(), m_clk()});
            end
        end
    endtask

    task automatic test_reset_mid();
        int k;
        set_div(3, 4);
        for (int c = 0; c < 3; c++) step();
        reset = 1'b1;
        bus.cfg_load = 1'b1;
        step();
        reset = 1'b0;
        bus.cfg_load = 1'b0;
        checks++;
        if ({bus.locked, bus.ce_out, bus.clk_out} !== 5'b0) begin
            failures++;
            $display("FAIL midreset_drop actual=%b expected=00000", {bus.locked, bus.ce_out, bus.clk_out});
        end
        for (int e = 1; e <= 17 + 12; e++) begin
            step();
            checks++;
            if (bus.locked !== (e >= 17)) begin
                failures++;
                $display("FAIL midreset_lock edge=%0d actual=%b expected=%b", e, bus.locked, e >= 17);
            end
            if (e >= 17) begin
                k = e - 17;
                checks++;
                if ({bus.ce_out, bus.clk_out} !== {k % 3 == 2, k % 4 == 3, k % 3 < 2, k % 4 < 2}) begin
                    failures++;
                    $display("FAIL midreset_pattern k=%0d actual=%b expected=%b", k,
                             {bus.ce_out, bus.clk_out}, {k % 3 == 2, k % 4 == 3, k % 3 < 2, k % 4 < 2});
                end
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            reset        = ($urandom_range(0, 199) == 0);
            bus.cfg_load = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 19) == 0) bus.ch_en = NUM_CH'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    bus.div_in[i*CNT_W +: CNT_W] = ($urandom_range(0, 7) == 0) ?
                        CNT_W'($urandom) : CNT_W'($urandom_range(0, 9));
                end
            end
            step();
            checks++;
            if ({bus.locked, bus.ce_out, bus.clk_out} !== {m_locked, m_ce(), m_clk()}) begin
                failures++;
                $display("FAIL random_model cycle=%0d actual=%b expected=%b", c,
                         {bus.locked, bus.ce_out, bus.clk_out}, {m_locked, m_ce(), m_clk()});
            end
        end
        reset        = 1'b0;
        bus.cfg_load = 1'b0;
    endtask

    initial begin
        bus.cfg_load = 1'b0;
        bus.ch_en    = 2'b11;
        bus.div_in   = '0;
        #2;
        test_reset();
        test_lock_basic();
        test_ch_en();
        test_redivide();
        test_div01();
        test_settle_restart();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
